// File: rtl/motor_cmd_sequencer.sv
// ============================================================================
// Module   : motor_cmd_sequencer
// Purpose  : Buffers packed two-motor speed commands, slew-limits each motor's
//            sign/magnitude on a prescaled step tick, inserts a zero-speed dead
//            time on every direction reversal and zeroes the targets when
//            commands stop arriving.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_cmd_sequencer #(
    parameter int RAMP_DIV    = 1000,
    parameter int STEP        = 2,
    parameter int DEAD_STEPS  = 4,
    parameter int MAX_COUNT   = 100,
    parameter int WDOG_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic        motor1_sign,
    output logic [6:0]  motor1_count,
    output logic        motor2_sign,
    output logic [6:0]  motor2_count,
    output logic        busy,
    output logic        wdog_fault
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam int DW = (DEAD_STEPS > 1) ? $clog2(DEAD_STEPS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_CYCLES - 1);
    localparam logic [WW-1:0] WDOG_MAX   = WW'(WDOG_CYCLES);
    localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_STEPS - 1);
    localparam logic [7:0]    STEP8      = 8'(STEP);
    localparam logic [6:0]    MAX7       = 7'(MAX_COUNT);

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } motor_state_t;

    logic [PW-1:0]     presc;
    logic [WW-1:0]     wdog_cnt;
    logic              hold_full;
    logic [1:0]        hold_sign;
    logic [1:0][6:0]   hold_mag;
    logic [1:0]        tgt_sign;
    logic [1:0][6:0]   tgt_mag;

    logic              step_tick;
    logic              accept;
    logic              wdog_expire;

    logic [1:0]        sign_vec;
    logic [1:0][6:0]   mag_vec;
    logic [1:0]        busy_vec;

    function automatic logic [6:0] clamp_mag(input logic [6:0] m);
        return (m > MAX7) ? MAX7 : m;
    endfunction

    assign step_tick   = (presc == PRESC_LAST);
    assign cmd_ready   = ~hold_full;
    assign accept      = cmd_valid & ~hold_full;
    // An accepted command on the expiry edge restarts the count instead.
    assign wdog_expire = ~accept & (wdog_cnt == WDOG_LAST);

    // Free-running prescaler producing one step_tick every RAMP_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (step_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Holding register, target registers and command watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt   <= '0;
            wdog_fault <= 1'b0;
            hold_full  <= 1'b0;
            hold_sign  <= '0;
            hold_mag   <= '0;
            tgt_sign   <= '0;
            tgt_mag    <= '0;
        end else begin
            if (accept) begin
                wdog_cnt   <= '0;
                wdog_fault <= 1'b0;
            end else begin
                if (wdog_cnt != WDOG_MAX) begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                end
                if (wdog_expire) begin
                    wdog_fault <= 1'b1;
                end
            end

            // Accept only happens while empty, so it never races the unload.
            if (accept) begin
                hold_full   <= 1'b1;
                hold_sign   <= {cmd_data[15], cmd_data[7]};
                hold_mag[1] <= clamp_mag(cmd_data[14:8]);
                hold_mag[0] <= clamp_mag(cmd_data[6:0]);
            end else if (wdog_expire || (step_tick && hold_full)) begin
                hold_full <= 1'b0;
            end

            // Expiry zeroes magnitudes but keeps signs, so the ramp-down
            // stays in the current direction.
            if (wdog_expire) begin
                tgt_mag <= '0;
            end else if (step_tick && hold_full) begin
                tgt_sign <= hold_sign;
                tgt_mag  <= hold_mag;
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_motor
        motor_state_t    state;
        logic            sign_q;
        logic [6:0]      mag_q;
        logic [DW-1:0]   dead_cnt;
        logic [7:0]      cur_ext;
        logic [7:0]      tgt_ext;
        logic [7:0]      gap;
        logic [7:0]      slew;
        logic [7:0]      shrink;
        logic            same_dir;

        assign cur_ext  = {1'b0, mag_q};
        assign tgt_ext  = {1'b0, tgt_mag[i]};
        assign gap      = (tgt_ext > cur_ext) ? (tgt_ext - cur_ext) : (cur_ext - tgt_ext);
        assign slew     = (gap < STEP8) ? gap : STEP8;
        assign shrink   = (cur_ext < STEP8) ? cur_ext : STEP8;
        assign same_dir = (tgt_sign[i] == sign_q) || (tgt_mag[i] == 7'd0);

        // Per-motor slew / dead-time FSM, advancing only on step_tick.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state    <= RUN;
                sign_q   <= 1'b0;
                mag_q    <= '0;
                dead_cnt <= '0;
            end else if (step_tick) begin
                case (state)
                    RUN: begin
                        if (same_dir) begin
                            if (tgt_ext > cur_ext) begin
                                mag_q <= 7'(cur_ext + slew);
                            end else begin
                                mag_q <= 7'(cur_ext - slew);
                            end
                        end else if (mag_q != 7'd0) begin
                            mag_q <= 7'(cur_ext - shrink);
                        end else if (DEAD_STEPS == 1) begin
                            sign_q <= tgt_sign[i];
                        end else begin
                            // This tick is the first of DEAD_STEPS zero ticks.
                            state    <= DEAD;
                            dead_cnt <= DEAD_LOAD;
                        end
                    end
                    DEAD: begin
                        // Flip on the tick the remaining count reaches zero;
                        // magnitude stays 0 on that tick.
                        if (dead_cnt == DW'(1)) begin
                            sign_q   <= tgt_sign[i];
                            state    <= RUN;
                            dead_cnt <= '0;
                        end else begin
                            dead_cnt <= dead_cnt - 1'b1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end

        assign sign_vec[i] = sign_q;
        assign mag_vec[i]  = mag_q;
        // A zero-magnitude target is met regardless of sign.
        assign busy_vec[i] = (state == DEAD) || (mag_q != tgt_mag[i]) ||
                             ((tgt_mag[i] != 7'd0) && (sign_q != tgt_sign[i]));
    end

    assign motor1_sign  = sign_vec[0];
    assign motor1_count = mag_vec[0];
    assign motor2_sign  = sign_vec[1];
    assign motor2_count = mag_vec[1];
    assign busy         = |busy_vec;

endmodule

`default_nettype wire
